// File: rtl/alu_op_responder_pkg.sv
// Shared opcode, FSM-state and width definitions for the flow-controlled ALU.
package alu_pkg;

  localparam int ALU_SEL_W = 4;

  typedef enum logic [ALU_SEL_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROL  = 4'h6,
    OP_ROR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RESP = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_op_responder_if.sv
// Request/response channel bundle between an operation initiator and the ALU responder.
interface alu_op_responder_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic [WIDTH-1:0]     req_a;
  logic [WIDTH-1:0]     req_b;
  logic [ALU_SEL_W-1:0] req_sel;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH-1:0]     rsp_out;
  logic                 rsp_carry;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_carry, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_carry, busy
  );
endinterface

// File: rtl/alu_seq_div.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, WIDTH cycles per divide.
module alu_seq_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             running_q;

  logic [WIDTH:0]   shifted, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next, quo_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], q_bit};
  end

  // The final quotient is presented combinationally on the done cycle so the
  // caller can register it on the same edge as the last iteration.
  assign quotient = quo_next;
  assign done     = running_q && (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else if (start) begin
      rem_q     <= '0;
      quo_q     <= dividend;
      dvs_q     <= divisor;
      cnt_q     <= '0;
      running_q <= 1'b1;
    end else if (running_q) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q + 1'b1;
      if (done) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_responder.sv
// Registered 16-op ALU behind valid/ready request and response channels; DIV is iterative.
module alu_op_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_responder_if.slave   bus
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] DIV  = ST_DIV;
  localparam logic [1:0] RESP = ST_RESP;

  logic [1:0]       state_q;
  logic             init_q;
  logic             rsp_valid_q, rsp_carry_q, busy_q;
  logic [WIDTH-1:0] rsp_out_q;

  logic             accept, div_start, div_done;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  alu_op_e          op;

  assign op = alu_op_e'(bus.req_sel);

  // init_q keeps req_ready low for the first cycle after reset release.
  assign bus.req_ready = init_q && ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));
  assign accept        = bus.req_valid && bus.req_ready;
  assign div_start     = accept && (op == OP_DIV) && (bus.req_b != '0);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.busy      = busy_q;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD:  {alu_carry, alu_res} = {1'b0, bus.req_a} + {1'b0, bus.req_b};
      OP_SUB:  begin
        alu_res   = bus.req_a - bus.req_b;
        alu_carry = bus.req_a < bus.req_b;
      end
      OP_MUL:  alu_res = bus.req_a * bus.req_b;
      // Only reached for a zero divisor; real divides go through the divider.
      OP_DIV:  begin
        alu_res   = '1;
        alu_carry = 1'b1;
      end
      OP_SHL:  {alu_carry, alu_res} = {bus.req_a, 1'b0};
      OP_SHR:  {alu_res, alu_carry} = {1'b0, bus.req_a};
      OP_ROL:  alu_res = {bus.req_a[WIDTH-2:0], bus.req_a[WIDTH-1]};
      OP_ROR:  alu_res = {bus.req_a[0], bus.req_a[WIDTH-1:1]};
      OP_AND:  alu_res = bus.req_a & bus.req_b;
      OP_OR:   alu_res = bus.req_a | bus.req_b;
      OP_XOR:  alu_res = bus.req_a ^ bus.req_b;
      OP_NOR:  alu_res = ~(bus.req_a | bus.req_b);
      OP_NAND: alu_res = ~(bus.req_a & bus.req_b);
      OP_XNOR: alu_res = ~(bus.req_a ^ bus.req_b);
      OP_GT:   alu_res = WIDTH'(bus.req_a > bus.req_b);
      OP_EQ:   alu_res = WIDTH'(bus.req_a == bus.req_b);
      default: alu_res = '0;
    endcase
  end

  alu_seq_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (bus.req_a),
    .divisor  (bus.req_b),
    .quotient (div_q),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      init_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      rsp_carry_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (accept) begin
        // An accept in RESP retires the current response on the same edge.
        if (div_start) begin
          state_q     <= DIV;
          busy_q      <= 1'b1;
          rsp_valid_q <= 1'b0;
        end else begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_out_q   <= alu_res;
          rsp_carry_q <= alu_carry;
        end
      end else begin
        case (state_q)
          DIV: if (div_done) begin
            state_q     <= RESP;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_out_q   <= div_q;
            rsp_carry_q <= 1'b0;
          end
          RESP: if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
          IDLE: ;
          default: begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_op_responder.sv
// Bench for alu_op_responder: vector table plus scoreboard, with hand-written DIV, backpressure and reset sequences.
module tb_alu_op_responder;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] out;
    logic       c;
  } vec_t;

  typedef struct packed {
    logic [7:0] out;
    logic       c;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_responder_if #(.WIDTH(W)) bus ();

  alu_op_responder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  rsp_t exp_q[$];
  vec_t vecs[22];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completed response handshake pops one expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_rsp_out", 32'(bus.rsp_out), 32'(e.out));
        check("sb_rsp_carry", 32'(bus.rsp_carry), 32'(e.c));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                      input logic [7:0] out, input logic c);
    int budget = 0;
    rsp_t e;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sel   = sel;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 200) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    e.out = out;
    e.c   = c;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c15;
    vecs[0]  = '{8'hAA, 8'h55, 4'h0, 8'hFF, 1'b0};
    vecs[1]  = '{8'hAA, 8'h55, 4'h1, 8'h55, 1'b0};
    vecs[2]  = '{8'hAA, 8'h55, 4'h2, 8'h72, 1'b0};
    vecs[3]  = '{8'hAA, 8'h55, 4'h3, 8'h02, 1'b0};
    vecs[4]  = '{8'hAA, 8'h55, 4'h4, 8'h54, 1'b1};
    vecs[5]  = '{8'hAA, 8'h55, 4'h5, 8'h55, 1'b0};
    vecs[6]  = '{8'hAA, 8'h55, 4'h6, 8'h55, 1'b0};
    vecs[7]  = '{8'hAA, 8'h55, 4'h7, 8'h55, 1'b0};
    vecs[8]  = '{8'hAA, 8'h55, 4'h8, 8'h00, 1'b0};
    vecs[9]  = '{8'hAA, 8'h55, 4'h9, 8'hFF, 1'b0};
    vecs[10] = '{8'hAA, 8'h55, 4'hA, 8'hFF, 1'b0};
    vecs[11] = '{8'hAA, 8'h55, 4'hB, 8'h00, 1'b0};
    vecs[12] = '{8'hAA, 8'h55, 4'hC, 8'hFF, 1'b0};
    vecs[13] = '{8'hAA, 8'h55, 4'hD, 8'h00, 1'b0};
    vecs[14] = '{8'hAA, 8'h55, 4'hE, 8'h01, 1'b0};
    vecs[15] = '{8'hAA, 8'h55, 4'hF, 8'h00, 1'b0};
    vecs[16] = '{8'h03, 8'h05, 4'h1, 8'hFE, 1'b1};
    vecs[17] = '{8'h81, 8'h00, 4'h5, 8'h40, 1'b1};
    vecs[18] = '{8'h80, 8'h00, 4'h6, 8'h01, 1'b0};
    vecs[19] = '{8'h01, 8'h00, 4'h7, 8'h80, 1'b0};
    vecs[20] = '{8'h10, 8'h10, 4'h2, 8'h00, 1'b0};
    vecs[21] = '{8'hF0, 8'h3C, 4'hD, 8'h33, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #3;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_out", 32'(bus.rsp_out), 32'd0);
    check("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    #20 rst_n = 1'b1;
    check("ready_low_at_release", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_release", 32'(bus.req_ready), 32'd1);

    // Basic ADD with carry, one-cycle latency
    bus.rsp_ready = 1'b1;
    send(8'hAA, 8'h55, 4'h0, 8'hFF, 1'b0);
    bus.req_valid = 1'b0;
    check("add1_valid", 32'(bus.rsp_valid), 32'd1);
    check("add1_out", 32'(bus.rsp_out), 32'hFF);
    send(8'hFF, 8'h01, 4'h0, 8'h00, 1'b1);
    bus.req_valid = 1'b0;
    check("add2_out", 32'(bus.rsp_out), 32'h00);
    check("add2_carry", 32'(bus.rsp_carry), 32'd1);
    @(posedge clk); #1;

    // Opcode sweep back-to-back, then extra vectors
    c0 = 0;
    c15 = 0;
    for (int i = 0; i < 22; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].out, vecs[i].c);
      if (i == 0) c0 = cycle;
      if (i == 15) c15 = cycle;
    end
    bus.req_valid = 1'b0;
    check("sweep_cycles", 32'(c15 - c0), 32'd23);
    repeat (2) begin @(posedge clk); #1; end

    // Division 200/7: eight busy cycles, then 0x1C
    send(8'd200, 8'd7, 4'h3, 8'h1C, 1'b0);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("div_busy", 32'(bus.busy), 32'd1);
      check("div_ready_low", 32'(bus.req_ready), 32'd0);
      check("div_no_valid", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("div_done_valid", 32'(bus.rsp_valid), 32'd1);
    check("div_out", 32'(bus.rsp_out), 32'h1C);
    check("div_busy_clear", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    // Divide by zero: single-cycle, all ones, carry set
    send(8'h12, 8'h00, 4'h3, 8'hFF, 1'b1);
    bus.req_valid = 1'b0;
    check("div0_valid", 32'(bus.rsp_valid), 32'd1);
    check("div0_out", 32'(bus.rsp_out), 32'hFF);
    check("div0_carry", 32'(bus.rsp_carry), 32'd1);
    check("div0_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("div0_busy_after", 32'(bus.busy), 32'd0);

    // Backpressure: response held, next request stalled, then same-cycle handoff
    bus.rsp_ready = 1'b0;
    send(8'h30, 8'h0C, 4'h0, 8'h3C, 1'b0);
    bus.req_a     = 8'h10;
    bus.req_b     = 8'h03;
    bus.req_sel   = 4'h1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_out_stable", 32'(bus.rsp_out), 32'h3C);
      check("bp_ready_low", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_ready_follows", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    exp_q.push_back('{8'h0D, 1'b0});
    bus.req_valid = 1'b0;
    check("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_next_out", 32'(bus.rsp_out), 32'h0D);
    @(posedge clk); #1;

    // Reset in the 4th DIV cycle discards the pending divide
    send(8'd200, 8'd7, 4'h3, 8'h1C, 1'b0);
    bus.req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_out", 32'(bus.rsp_out), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd0);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    send(8'h01, 8'h02, 4'h0, 8'h03, 1'b0);
    bus.req_valid = 1'b0;
    check("post_rst_out", 32'(bus.rsp_out), 32'h03);
    check("post_rst_valid", 32'(bus.rsp_valid), 32'd1);

    repeat (3) begin @(posedge clk); #1; end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
